// File: rtl/byte_serial_accumulator.sv
// Byte-serial accumulator: sequences 8-bit operands through an external
// combinational 8-bit adder, one accumulator byte per cycle, and presents the
// wide running sum with a sticky overflow flag and an operand count at end of
// packet.
module byte_serial_accumulator #(
  parameter int unsigned ACC_BYTES = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  output logic                   add_cin,
  input  logic [7:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*ACC_BYTES-1:0] out_sum,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_count
);

  localparam int unsigned SumW = 8 * ACC_BYTES;
  localparam int unsigned IdxW = $clog2(ACC_BYTES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(ACC_BYTES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SumW-1:0]  acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       op_q, op_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake and adder drive, decoded from the current state and byte index.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    case (state_q)
      // Gate with rst_n so nothing is accepted while reset is held.
      StIdle: in_ready = rst_n;
      StAdd: begin
        for (int i = 0; i < ACC_BYTES; i++) begin
          if (idx_q == IdxW'(i)) add_a = acc_q[8*i +: 8];
        end
        // Operand enters only at the low byte; higher bytes just ripple carry.
        add_b   = (idx_q == '0) ? op_q : 8'h00;
        add_cin = (idx_q == '0) ? 1'b0 : carry_q;
      end
      StDone: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic for the sequencer and accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    op_d    = op_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          op_d    = in_data;
          last_d  = in_last;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int i = 0; i < ACC_BYTES; i++) begin
          if (idx_q == IdxW'(i)) acc_d[8*i +: 8] = add_s;
        end
        carry_d = add_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == IdxLast) begin
          idx_d = '0;
          ovf_d = ovf_q | add_cout;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = last_q ? StDone : StIdle;
        end
      end
      StDone: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      op_q    <= 8'h00;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_byte_serial_accumulator.sv
// Scoreboard bench for byte_serial_accumulator with ACC_BYTES=2 and ACC_BYTES=4
// instances, each closed around a behavioural 8-bit adder.
module tb_byte_serial_accumulator;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t sb2[$];
  exp_t sb4[$];

  // ACC_BYTES=2 instance
  logic        in_valid, in_ready, in_last, add_cin, add_cout;
  logic        out_valid, out_ready, out_ovf;
  logic [7:0]  in_data, add_a, add_b, add_s, out_count;
  logic [15:0] out_sum;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  byte_serial_accumulator #(.ACC_BYTES(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_count(out_count)
  );

  // ACC_BYTES=4 instance
  logic        in_valid4, in_ready4, in_last4, add_cin4, add_cout4;
  logic        out_valid4, out_ready4, out_ovf4;
  logic [7:0]  in_data4, add_a4, add_b4, add_s4, out_count4;
  logic [31:0] out_sum4;

  assign {add_cout4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'd0, add_cin4};

  byte_serial_accumulator #(.ACC_BYTES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_s(add_s4),
    .add_cout(add_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_ovf(out_ovf4),
    .out_count(out_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push2(input logic [31:0] s, input logic o, input logic [7:0] c);
    exp_t e;
    e.sum = s; e.ovf = o; e.cnt = c;
    sb2.push_back(e);
  endtask

  task automatic push4(input logic [31:0] s, input logic o, input logic [7:0] c);
    exp_t e;
    e.sum = s; e.ovf = o; e.cnt = c;
    sb4.push_back(e);
  endtask

  int acc_cyc2, acc_cyc4;

  // Leaves in_valid high on return; caller drops it after a packet's last beat.
  task automatic send2(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send2_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
      acc_cyc2 = cyc;
    end
  endtask

  task automatic send4(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid4 = 1'b1; in_data4 = d; in_last4 = l;
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready4) begin
      checks++; errors++;
      $display("FAIL send4_timeout: in_ready=%0b required 1", in_ready4);
    end else begin
      @(posedge clk); #1;
      acc_cyc4 = cyc;
    end
  endtask

  task automatic wait_valid2(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    while (!out_valid4 && lat < 20) begin @(negedge clk); lat++; end
  endtask

  // Monitors: pop and compare on every accepted result.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out2: sum=0x%0h with no result required", out_sum);
      end else begin
        e = sb2.pop_front();
        chk("out_sum2", {16'd0, out_sum}, e.sum);
        chk("out_ovf2", {31'd0, out_ovf}, {31'd0, e.ovf});
        chk("out_count2", {24'd0, out_count}, {24'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out4: sum=0x%0h with no result required", out_sum4);
      end else begin
        e = sb4.pop_front();
        chk("out_sum4", out_sum4, e.sum);
        chk("out_ovf4", {31'd0, out_ovf4}, {31'd0, e.ovf});
        chk("out_count4", {24'd0, out_count4}, {24'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, t0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    in_valid4 = 0; in_data4 = 0; in_last4 = 0; out_ready4 = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_count", {24'd0, out_count}, 0);
    chk("rst_out_sum", {16'd0, out_sum}, 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk("rst_add_a", {24'd0, add_a}, 0);
    chk("rst_add_b", {24'd0, add_b}, 0);
    chk("rst_add_cin", {31'd0, add_cin}, 0);
    chk("rst_in_ready4", {31'd0, in_ready4}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 1);

    // Three-operand packet and last-result latency.
    push2(32'h0060, 1'b0, 8'd3);
    send2(8'h10, 1'b0);
    send2(8'h20, 1'b0);
    send2(8'h30, 1'b1);
    in_valid = 0;
    wait_valid2(lat);
    chk("last_latency", lat, 3);

    // Carry ripples into the high byte.
    push2(32'h0100, 1'b0, 8'd2);
    send2(8'hFF, 1'b0);
    send2(8'h01, 1'b1);
    in_valid = 0;
    @(negedge clk);
    chk("lo_add_a", {24'd0, add_a}, 32'hFF);
    chk("lo_add_b", {24'd0, add_b}, 32'h01);
    chk("lo_add_cin", {31'd0, add_cin}, 0);
    @(negedge clk);
    chk("hi_add_a", {24'd0, add_a}, 0);
    chk("hi_add_b", {24'd0, add_b}, 0);
    chk("hi_add_cin", {31'd0, add_cin}, 1);
    wait_valid2(lat);

    // Wraparound, sticky overflow and saturating count.
    push2(32'h00FE, 1'b1, 8'd255);
    for (int i = 0; i < 257; i++) send2(8'hFF, 1'b0);
    send2(8'hFF, 1'b1);
    in_valid = 0;
    wait_valid2(lat);

    // Back-to-back operands with in_valid held, then downstream stall.
    push2(32'h000A, 1'b0, 8'd4);
    send2(8'h01, 1'b0);
    t0 = acc_cyc2;
    send2(8'h02, 1'b0);
    chk("period2_a", acc_cyc2 - t0, 3);
    t0 = acc_cyc2;
    send2(8'h03, 1'b0);
    chk("period2_b", acc_cyc2 - t0, 3);
    t0 = acc_cyc2;
    send2(8'h04, 1'b1);
    chk("period2_c", acc_cyc2 - t0, 3);
    in_valid = 0;
    out_ready = 0;
    wait_valid2(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_out_sum", {16'd0, out_sum}, 32'h000A);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1;
    push2(32'h0005, 1'b0, 8'd1);
    send2(8'h05, 1'b1);
    in_valid = 0;
    wait_valid2(lat);

    // Asynchronous reset during the high-byte add of the second operand.
    send2(8'h11, 1'b0);
    send2(8'h22, 1'b1);
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_out_count", {24'd0, out_count}, 0);
    chk("arst_out_sum", {16'd0, out_sum}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    push2(32'h0007, 1'b0, 8'd1);
    send2(8'h07, 1'b1);
    in_valid = 0;
    wait_valid2(lat);

    // Four-byte accumulator.
    push4(32'h000002FD, 1'b0, 8'd3);
    send4(8'hFF, 1'b0);
    t0 = acc_cyc4;
    send4(8'hFF, 1'b0);
    chk("period4_a", acc_cyc4 - t0, 5);
    t0 = acc_cyc4;
    send4(8'hFF, 1'b1);
    chk("period4_b", acc_cyc4 - t0, 5);
    in_valid4 = 0;
    wait_valid4(lat);
    chk("last_latency4", lat, 5);

    repeat (4) @(negedge clk);
    chk("sb2_drained", sb2.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
